// File: rtl/pattern_fetch_arbiter_if.sv
// rtl/pattern_fetch_arbiter_if.sv - decoder-side and memory-side signals of the pattern fetch arbiter
interface pattern_fetch_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 48,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 16
) ();
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ack;
  logic                          mem_req;
  logic [ADDR_WIDTH-1:0]         mem_req_addr;
  logic                          mem_stall;
  logic                          mem_push;
  logic [DATA_WIDTH-1:0]         mem_data;
  logic [NUM_REQ-1:0]            push;
  logic [DATA_WIDTH-1:0]         data;
  logic [CNT_W-1:0]              outstanding;
  logic                          err;

  modport slave (
    input  req, req_addr, mem_stall, mem_push, mem_data,
    output req_ack, mem_req, mem_req_addr, push, data, outstanding, err
  );

  modport master (
    output req, req_addr, mem_stall, mem_push, mem_data,
    input  req_ack, mem_req, mem_req_addr, push, data, outstanding, err
  );
endinterface

// File: rtl/pattern_fetch_arbiter.sv
// rtl/pattern_fetch_arbiter.sv - round-robin read-port arbiter with in-order tag FIFO for response steering
module pattern_fetch_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ID_WIDTH        = 2,
  parameter int ADDR_WIDTH      = 48,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pattern_fetch_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_REQ-1:0]    r_req_ack;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_req_addr;
  logic [NUM_REQ-1:0]    r_push;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_W-1:0]      r_outstanding;
  logic                  r_err;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [ID_WIDTH-1:0]   r_tag_mem [MAX_OUTSTANDING];

  logic [NUM_REQ-1:0]    w_eligible;
  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_winner;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic                  w_grant;
  logic                  w_pop;
  logic [ID_WIDTH-1:0]   w_head;
  logic [NUM_REQ-1:0]    w_head_onehot;
  logic [ID_WIDTH-1:0]   w_next_rr;

  assign w_eligible = bus.req & ~r_req_ack;
  assign w_head     = r_tag_mem[r_rd_ptr];
  assign w_grant    = rst && w_found && !bus.mem_stall && (r_outstanding < CNT_MAX);
  assign w_pop      = rst && bus.mem_push && (r_outstanding != '0);
  assign w_next_rr  = (w_winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

  // Winner is the eligible requester at the smallest rotational distance from rr_ptr.
  always_comb begin : winner_select
    int best_d;
    int d_i;
    best_d     = NUM_REQ;
    d_i        = 0;
    w_found    = 1'b0;
    w_winner   = '0;
    w_win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d_i = (i + NUM_REQ - int'(r_rr_ptr)) % NUM_REQ;
      if (w_eligible[i] && (d_i < best_d)) begin
        best_d   = d_i;
        w_winner = ID_WIDTH'(i);
        w_found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_WIDTH'(i)) begin
        w_win_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    w_head_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_head_onehot[i] = (w_head == ID_WIDTH'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req_ack      <= '0;
      r_mem_req      <= 1'b0;
      r_mem_req_addr <= '0;
      r_push         <= '0;
      r_data         <= '0;
      r_outstanding  <= '0;
      r_err          <= 1'b0;
      r_rr_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
    end else begin
      r_mem_req <= w_grant;
      r_req_ack <= '0;
      r_push    <= '0;
      if (w_grant) begin
        r_mem_req_addr      <= w_win_addr;
        r_req_ack[w_winner] <= 1'b1;
        r_rr_ptr            <= w_next_rr;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_push   <= w_head_onehot;
        r_data   <= bus.mem_data;
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end else if (bus.mem_push) begin
        r_err <= 1'b1;
      end
      case ({w_grant, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Tag storage needs no reset; emptiness is tracked by the outstanding count.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_tag_mem[r_wr_ptr] <= w_winner;
    end
  end

  assign bus.req_ack      = r_req_ack;
  assign bus.mem_req      = r_mem_req;
  assign bus.mem_req_addr = r_mem_req_addr;
  assign bus.push         = r_push;
  assign bus.data         = r_data;
  assign bus.outstanding  = r_outstanding;
  assign bus.err          = r_err;
endmodule

// File: tb/tb_pattern_fetch_arbiter.sv
// tb/tb_pattern_fetch_arbiter.sv - scoreboard bench for pattern_fetch_arbiter
module tb_pattern_fetch_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int MO = 16;

  typedef struct {
    int          cyc;
    int          id;
    logic [63:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pattern_fetch_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) bus ();

  pattern_fetch_arbiter #(
    .NUM_REQ(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int     m_cyc = 0;
  int     m_rr  = 0;
  int     m_tags[$];
  logic [N-1:0] m_ack_prev = '0;
  bit     m_err = 0;
  int     e_out = 0;
  bit     e_err = 0;
  ev_t    gq[$];
  ev_t    rq[$];
  bit     mon_en = 0;

  // stimulus modes
  int req_mode   = 0;   // 0 manual, 1 random, 2 hold all
  int push_mode  = 0;   // 0 off, 1 random while tags pending
  int stall_mode = 0;   // 0 forced value, 1 random
  bit stall_force = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic fail_event(string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, m_cyc);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[AW-1:0];
  endfunction

  function automatic logic [63:0] rand_data();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t;
  endfunction

  // Model: arbitration and tag ordering from the behavioural rules, using queues.
  initial begin
    logic [N-1:0] elig;
    bit g;
    int win;
    int idx;
    ev_t ev;
    forever begin
      @(posedge clk);
      m_cyc++;
      if (!rst) begin
        m_rr = 0;
        m_tags.delete();
        m_ack_prev = '0;
        m_err = 0;
      end else begin
        elig = bus.req & ~m_ack_prev;
        g = 0;
        win = 0;
        if (elig != '0 && !bus.mem_stall && m_tags.size() < MO) begin
          for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (!g && elig[idx]) begin
              g = 1;
              win = idx;
            end
          end
        end
        if (bus.mem_push) begin
          if (m_tags.size() > 0) begin
            ev.cyc = m_cyc;
            ev.id  = m_tags.pop_front();
            ev.val = bus.mem_data;
            rq.push_back(ev);
          end else begin
            m_err = 1;
          end
        end
        m_ack_prev = '0;
        if (g) begin
          ev.cyc = m_cyc;
          ev.id  = win;
          ev.val = 64'(bus.req_addr[win*AW +: AW]);
          gq.push_back(ev);
          m_tags.push_back(win);
          m_rr = (win + 1) % N;
          m_ack_prev[win] = 1'b1;
        end
      end
      e_out = m_tags.size();
      e_err = m_err;
    end
  end

  // Monitor: pops expected events whenever the DUT presents an output.
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.mem_req) begin
          if (gq.size() == 0) fail_event("grant_unexpected");
          else begin
            ev = gq.pop_front();
            chk("grant_cycle", 64'(m_cyc), 64'(ev.cyc));
            chk("grant_addr", 64'(bus.mem_req_addr), ev.val);
            chk("grant_ack", 64'(bus.req_ack), 64'(1) << ev.id);
          end
        end else begin
          if (bus.req_ack != '0) chk("ack_without_req", 64'(bus.req_ack), 64'(0));
          if (gq.size() > 0 && gq[0].cyc <= m_cyc) begin
            fail_event("grant_missing");
            gq.delete(0);
          end
        end
        if (bus.push != '0) begin
          if (rq.size() == 0) fail_event("push_unexpected");
          else begin
            ev = rq.pop_front();
            chk("push_cycle", 64'(m_cyc), 64'(ev.cyc));
            chk("push_onehot", 64'(bus.push), 64'(1) << ev.id);
            chk("push_data", bus.data, ev.val);
          end
        end else if (rq.size() > 0 && rq[0].cyc <= m_cyc) begin
          fail_event("push_missing");
          rq.delete(0);
        end
        chk("outstanding", 64'(bus.outstanding), 64'(e_out));
        chk("err", 64'(bus.err), 64'(e_err));
      end
    end
  end

  task automatic step(int n);
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && bus.req_ack[i]) begin
          if (req_mode == 2 || (req_mode == 1 && $urandom_range(1, 0) == 1))
            bus.req_addr[i*AW +: AW] = rand_addr();
          else
            bus.req[i] = 1'b0;
        end else if (!bus.req[i]) begin
          if (req_mode == 2 || (req_mode == 1 && $urandom_range(9, 0) < 3)) begin
            bus.req[i] = 1'b1;
            bus.req_addr[i*AW +: AW] = rand_addr();
          end
        end else if (req_mode == 1 && $urandom_range(99, 0) < 3) begin
          bus.req[i] = 1'b0;
        end
      end
      bus.mem_push  = (push_mode == 1) && (m_tags.size() > 0) && ($urandom_range(9, 0) < 4);
      bus.mem_data  = rand_data();
      bus.mem_stall = (stall_mode == 1) ? ($urandom_range(9, 0) < 2) : stall_force;
    end
  endtask

  task automatic reset_dut();
    req_mode = 0; push_mode = 0; stall_mode = 0; stall_force = 0;
    bus.req = '0;
    bus.mem_push = 1'b0;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    int cnt;
    int ids[$];
    int bound;
    rst = 1'b0;
    bus.req = '0; bus.req_addr = '0; bus.mem_stall = 1'b0; bus.mem_push = 1'b0; bus.mem_data = '0;
    step(1);
    mon_en = 1;
    reset_dut();
    chk("rst_mem_req_addr", 64'(bus.mem_req_addr), 64'(0));
    chk("rst_data", bus.data, 64'(0));
    chk("rst_push", 64'(bus.push), 64'(0));
    chk("rst_mem_req", 64'(bus.mem_req), 64'(0));

    // single requester, then its response
    bus.req[2] = 1'b1;
    bus.req_addr[2*AW +: AW] = 48'h10;
    step(1);
    chk("t1_mem_req", 64'(bus.mem_req), 64'(1));
    chk("t1_addr", 64'(bus.mem_req_addr), 64'h10);
    chk("t1_ack", 64'(bus.req_ack), 64'b0100);
    bus.mem_push = 1'b1;
    bus.mem_data = 64'hABCD;
    step(1);
    chk("t1_push", 64'(bus.push), 64'b0100);
    chk("t1_data", bus.data, 64'hABCD);

    // all requesters held: rotation order
    reset_dut();
    req_mode = 2; push_mode = 1;
    for (int s = 0; s < 30 && ids.size() < 5; s++) begin
      step(1);
      if (bus.mem_req)
        for (int i = 0; i < N; i++) if (bus.req_ack[i]) ids.push_back(i);
    end
    if (ids.size() < 5) fail_event("t2_timeout");
    else begin
      chk("t2_g0", 64'(ids[0]), 64'(0));
      chk("t2_g1", 64'(ids[1]), 64'(1));
      chk("t2_g2", 64'(ids[2]), 64'(2));
      chk("t2_g3", 64'(ids[3]), 64'(3));
      chk("t2_g4", 64'(ids[4]), 64'(0));
    end

    // stall holds off issue; first issue one cycle after stall drops
    reset_dut();
    req_mode = 2; push_mode = 1; stall_force = 1;
    step(1);
    for (int s = 0; s < 3; s++) begin
      step(1);
      chk("t3_stalled", 64'(bus.mem_req), 64'(0));
    end
    stall_force = 0;
    step(1);
    chk("t3_stall_drop_edge", 64'(bus.mem_req), 64'(0));
    step(1);
    chk("t3_first_issue", 64'(bus.mem_req), 64'(1));

    // fill to the outstanding limit
    reset_dut();
    req_mode = 2;
    cnt = 0;
    for (int s = 0; s < 25; s++) begin
      step(1);
      if (bus.mem_req) cnt++;
    end
    chk("t4_grants", 64'(cnt), 64'(16));
    chk("t4_full", 64'(bus.outstanding), 64'(16));
    bus.mem_push = 1'b1;
    step(1);
    chk("t4_after_pop", 64'(bus.outstanding), 64'(15));
    chk("t4_no_grant_on_pop", 64'(bus.mem_req), 64'(0));
    step(1);
    chk("t4_regrant", 64'(bus.mem_req), 64'(1));
    chk("t4_refull", 64'(bus.outstanding), 64'(16));

    // interleaved issue 1,3,0 and steered responses
    reset_dut();
    bus.req[1] = 1'b1; bus.req_addr[1*AW +: AW] = 48'h111;
    step(1);
    bus.req[3] = 1'b1; bus.req_addr[3*AW +: AW] = 48'h333;
    step(1);
    bus.req[0] = 1'b1; bus.req_addr[0*AW +: AW] = 48'h000;
    step(1);
    step(1);
    bus.mem_push = 1'b1; bus.mem_data = 64'hD1;
    step(1);
    chk("t5_push1", 64'(bus.push), 64'b0010);
    chk("t5_data1", bus.data, 64'hD1);
    bus.mem_push = 1'b1; bus.mem_data = 64'hD3;
    step(1);
    chk("t5_push3", 64'(bus.push), 64'b1000);
    chk("t5_data3", bus.data, 64'hD3);
    bus.mem_push = 1'b1; bus.mem_data = 64'hD0;
    step(1);
    chk("t5_push0", 64'(bus.push), 64'b0001);
    chk("t5_data0", bus.data, 64'hD0);

    // unexpected response sets sticky err
    reset_dut();
    bus.mem_push = 1'b1;
    step(1);
    chk("t6_push_dropped", 64'(bus.push), 64'(0));
    chk("t6_err", 64'(bus.err), 64'(1));
    step(3);
    chk("t6_err_sticky", 64'(bus.err), 64'(1));
    rst = 1'b0;
    step(1);
    chk("t6_err_cleared", 64'(bus.err), 64'(0));
    rst = 1'b1;

    // randomized traffic
    reset_dut();
    req_mode = 1; push_mode = 1; stall_mode = 1;
    step(3000);

    // drain
    req_mode = 0; stall_mode = 0; stall_force = 0;
    bus.req = '0;
    bound = 0;
    while (m_tags.size() > 0 && bound < 400) begin
      step(1);
      bound++;
    end
    if (m_tags.size() > 0) fail_event("drain_timeout");
    step(3);
    chk("gq_drained", 64'(gq.size()), 64'(0));
    chk("rq_drained", 64'(rq.size()), 64'(0));
    chk("final_outstanding", 64'(bus.outstanding), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
